adc_frame_tx: RTL

Multi-channel successor to the single-channel filtered-sample UART sender. It captures CHANNELS filtered sinc3 words on one word-clock strobe and packs them into one framed packet: sync byte, sequence number, channel data, checksum. It serialises the packet on an integrated 8N1 UART. It sits after the per-channel filters and drives the board TX pin directly.

---
 rtl/adc_frame_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/adc_frame_tx.sv
// adc_frame_tx: latches one multi-channel sample set per strobe and sends it as a framed 8N1 UART packet
module adc_frame_tx #(
    parameter int         CHANNELS  = 2,
    parameter int         WIDTH     = 16,
    parameter int         CLK_FREQ  = 75_000_000,
    parameter int         BAUDRATE  = 115200,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sample_valid,
    input  logic [CHANNELS*WIDTH-1:0] sample_data,
    output logic                      tx,
    output logic                      busy,
    output logic                      overrun,
    output logic [7:0]                seq
);
    localparam int DIV    = CLK_FREQ / BAUDRATE;
    localparam int BPC    = (WIDTH + 7) / 8;
    localparam int NDATA  = CHANNELS * BPC;
    localparam int NBYTES = NDATA + 3;
    localparam int CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW     = $clog2(NBYTES);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]                state;
    logic [CW-1:0]             baud_cnt;
    logic                      baud_done;
    logic [2:0]                bit_cnt;
    logic [BW-1:0]             byte_idx;
    logic [7:0]                shift;
    logic [CHANNELS*WIDTH-1:0] shadow;
    logic [7:0]                seq_lat;
    logic [NDATA*8-1:0]        padded;
    logic [7:0]                data_bytes [NDATA];
    logic [7:0]                frame [NBYTES];
    logic [7:0]                checksum;

    assign busy      = state != IDLE;
    assign baud_done = baud_cnt == BAUD_LAST;

    // zero-extend each latched channel to a whole number of bytes
    always_comb begin
        padded = '0;
        for (int k = 0; k < CHANNELS; k++)
            padded[k*BPC*8 +: WIDTH] = shadow[k*WIDTH +: WIDTH];
    end

    // channel bytes in send order: channel 0 first, MSB byte of each channel first
    always_comb begin
        for (int j = 0; j < NDATA; j++)
            data_bytes[j] = padded[((j / BPC) * BPC + (BPC - 1 - j % BPC)) * 8 +: 8];
    end

    // assemble the full frame; checksum covers seq and data, not the sync byte
    always_comb begin
        checksum = seq_lat;
        for (int j = 0; j < NDATA; j++)
            checksum = checksum + data_bytes[j];
        frame[0] = SYNC_BYTE;
        frame[1] = seq_lat;
        for (int j = 0; j < NDATA; j++)
            frame[j+2] = data_bytes[j];
        frame[NBYTES-1] = checksum;
    end

    // strobes that arrive while a frame is in flight are dropped and flagged
    always_ff @(posedge clk) begin
        if (rst)
            overrun <= 1'b0;
        else
            overrun <= sample_valid && busy;
    end

    // snapshot samples and sequence number at accept so the frame is stable while sending
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            seq_lat <= '0;
        end else if (state == IDLE && sample_valid) begin
            shadow  <= sample_data;
            seq_lat <= seq;
        end
    end

    // bit-period counter, free-running only while a frame is in flight
    always_ff @(posedge clk) begin
        if (rst)
            baud_cnt <= '0;
        else
            baud_cnt <= (state == IDLE || baud_done) ? '0 : baud_cnt + 1'b1;
    end

    // UART sequencer: start, 8 data bits LSB first, stop, back-to-back across frame bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            byte_idx <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            seq      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        state    <= START;
                        byte_idx <= '0;
                        tx       <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx      <= frame[byte_idx][0];
                        shift   <= frame[byte_idx] >> 1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
                end
                default: begin
                    if (baud_done) begin
                        if (byte_idx == BYTE_LAST) begin
                            state <= IDLE;
                            seq   <= seq + 1'b1;
                        end else begin
                            state    <= START;
                            byte_idx <= byte_idx + 1'b1;
                            tx       <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end
endmodule
